lcd_frame_scanner: RTL and testbench
====================================

Name: lcd_frame_scanner

Overview:
- Read-side client of the 256x4 LCD video RAM; the CPU writes segments through port A, this block reads through port B.
- On request it walks the 32x16 pixel area in raster order and emits one pixel per handshake to the display/scaler pipeline.
- After the pixel area it fetches two icon nibbles and publishes the 8 icon bits atomically with a frame-done pulse.

Parameters:
- COLS, 32, pixel columns per row; power of two.
- ROWS, 16, pixel rows; multiple of 4, because each nibble holds 4 vertically stacked pixels.
- ICON_BASE, 8'h80, video RAM address of the first icon nibble; the second icon nibble is at ICON_BASE+1.

Ports:
- clock  in  1  system clock; the only clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  single-cycle frame request.
- busy  out  1  high from the accepted start until the cycle of frame_done.
- vram_address  out  8  address to video RAM port B (write enable tied low externally).
- vram_q  in  4  port B read data; registered, valid 1 cycle after the address is presented.
- pixel_valid  out  1  pixel offer.
- pixel_ready  in  1  consumer accepts the pixel when valid && ready.
- pixel  out  1  segment on/off.
- pixel_x  out  5  column, 0..COLS-1.
- pixel_y  out  4  row, 0..ROWS-1.
- pixel_last  out  1  high with the pixel at (COLS-1, ROWS-1).
- icons  out  8  {nibble[ICON_BASE+1], nibble[ICON_BASE]}; held between frames.
- frame_done  out  1  single-cycle pulse when icons update.

Behaviour:
- Reset values: busy=0, vram_address=0, pixel_valid=0, pixel=0, pixel_x=0, pixel_y=0, pixel_last=0, icons=0, frame_done=0. State goes to IDLE.
- Reset has priority over all other inputs. Reset mid-frame abandons the frame immediately: no frame_done, icons cleared.
- Address mapping: pixel (x,y) is at address (y>>2)*COLS + x, bit y[1:0] of the nibble.
- Address arithmetic is 8-bit; the pixel area must satisfy (ROWS/4)*COLS <= ICON_BASE. With defaults the pixel area is 0x00..0x7F.
- States:
  - IDLE: on start go to READ with x=0, y=0, busy=1. Otherwise stay.
  - READ: vram_address = pixel address; next state CAPTURE.
  - CAPTURE: vram_q is valid. Latch pixel = vram_q[y[1:0]], pixel_x, pixel_y and pixel_last; set pixel_valid=1; go to OFFER.
  - OFFER: hold pixel_valid and all pixel fields stable until pixel_ready. On the accepting edge drop pixel_valid and advance x (wrap at COLS-1 to 0, increment y). If the accepted pixel was last, go to ICON0; else go to READ.
  - ICON0: vram_address = ICON_BASE; next state ICON1.
  - ICON1: vram_address = ICON_BASE+1; capture vram_q into a low-nibble holding register; next state ICON2.
  - ICON2: icons <= {vram_q, held low nibble}; frame_done=1 for this one cycle; busy=0; go to IDLE.
- Pixel throughput: minimum 3 cycles per pixel (READ, CAPTURE, OFFER with ready high).
- Latency: start to first pixel_valid = 2 cycles after the start edge.
- pixel_ready while pixel_valid=0 is ignored. pixel_valid never drops without acceptance.
- start while busy is ignored (not queued). start in the same cycle as frame_done is also ignored; the next start is accepted from IDLE.
- The RAM may be written by the CPU mid-frame. The block samples whatever each read returns; there is no tearing protection.
- icons and pixel fields are never partially updated.

Decomposition:
- Shared package lcd_pkg: constants LCD_COLS=32, LCD_ROWS=16, LCD_ICON_BASE=8'h80.
- lcd_pkg: scanner state enum (IDLE, READ, CAPTURE, OFFER, ICON0, ICON1, ICON2).
- lcd_pkg: function pixel_address(x, y).
- No sub-module required. The bench reuses the existing video_ram model on port B.

Test Plan:
- RAM all zero except nibble 0x00=4'b1010; start with ready tied high -> pixels (0,1) and (0,3) are 1, all others 0; exactly 512 handshakes; pixel_last only on (31,15); frame_done once; icons=8'h00.
- Nibble 0x80=4'h5, 0x81=4'hC -> icons=8'hC5 in the frame_done cycle and held afterwards; icons unchanged before that cycle.
- Random pixel_ready backpressure (50%) with a known RAM image -> received stream equals the reference raster; fields stable while valid && !ready.
- Ready high throughout -> first pixel_valid 2 cycles after start; consecutive accepts exactly 3 cycles apart; busy low in the cycle after frame_done.
- start pulsed again mid-frame and in the frame_done cycle -> exactly one frame produced; a later start in IDLE produces a second full frame.
- reset asserted during pixel (10,5) OFFER -> next cycle pixel_valid=0, busy=0, icons=0; no frame_done; a new start restarts at (0,0).

Source files
------------

// File: rtl/lcd_pkg.sv
// Shared constants, scanner state encoding and the pixel-to-VRAM address map
// for the LCD frame scanner.
package lcd_pkg;

  localparam int LCD_COLS = 32;
  localparam int LCD_ROWS = 16;
  localparam logic [7:0] LCD_ICON_BASE = 8'h80;

  localparam int X_W = $clog2(LCD_COLS);
  localparam int Y_W = $clog2(LCD_ROWS);
  localparam logic [X_W-1:0] X_LAST = X_W'(LCD_COLS - 1);
  localparam logic [Y_W-1:0] Y_LAST = Y_W'(LCD_ROWS - 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    READ    = 3'd1,
    CAPTURE = 3'd2,
    OFFER   = 3'd3,
    ICON0   = 3'd4,
    ICON1   = 3'd5,
    ICON2   = 3'd6
  } scan_state_e;

  // Each nibble stacks four rows, so a row band of 4 pixels shares one address.
  function automatic logic [7:0] pixel_address(input logic [X_W-1:0] x,
                                               input logic [Y_W-1:0] y);
    logic [7:0] band;
    band = 8'(y >> 2);
    return 8'(band * 8'(LCD_COLS)) + 8'(x);
  endfunction

endpackage

// File: rtl/lcd_frame_scanner.sv
// Walks the LCD video RAM in raster order, offering one pixel per handshake,
// then fetches the two icon nibbles and publishes them with a frame-done pulse.
module lcd_frame_scanner
  import lcd_pkg::*;
(
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  output logic             busy,
  output logic [7:0]       vram_address,
  input  logic [3:0]       vram_q,
  output logic             pixel_valid,
  input  logic             pixel_ready,
  output logic             pixel,
  output logic [X_W-1:0]   pixel_x,
  output logic [Y_W-1:0]   pixel_y,
  output logic             pixel_last,
  output logic [7:0]       icons,
  output logic             frame_done
);

  scan_state_e state_q, state_d;
  logic [X_W-1:0] x_q, x_d, x_next_s;
  logic [Y_W-1:0] y_q, y_d, y_next_s;
  logic           busy_q, busy_d;
  logic [7:0]     addr_q, addr_d;
  logic           valid_q, valid_d;
  logic           pix_q, pix_d;
  logic [X_W-1:0] px_q, px_d;
  logic [Y_W-1:0] py_q, py_d;
  logic           last_q, last_d;
  logic [3:0]     icon_lo_q, icon_lo_d;
  logic [7:0]     icons_q, icons_d;
  logic           done_q, done_d;

  // State and output registers; reset abandons any frame in flight.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= IDLE;
      x_q       <= '0;
      y_q       <= '0;
      busy_q    <= 1'b0;
      addr_q    <= 8'h00;
      valid_q   <= 1'b0;
      pix_q     <= 1'b0;
      px_q      <= '0;
      py_q      <= '0;
      last_q    <= 1'b0;
      icon_lo_q <= 4'h0;
      icons_q   <= 8'h00;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      x_q       <= x_d;
      y_q       <= y_d;
      busy_q    <= busy_d;
      addr_q    <= addr_d;
      valid_q   <= valid_d;
      pix_q     <= pix_d;
      px_q      <= px_d;
      py_q      <= py_d;
      last_q    <= last_d;
      icon_lo_q <= icon_lo_d;
      icons_q   <= icons_d;
      done_q    <= done_d;
    end
  end

  // Next-state logic; addresses are registered one state ahead so the RAM
  // read latency lines up with CAPTURE / ICON1 / ICON2.
  always_comb begin
    state_d   = state_q;
    x_d       = x_q;
    y_d       = y_q;
    busy_d    = busy_q;
    addr_d    = addr_q;
    valid_d   = valid_q;
    pix_d     = pix_q;
    px_d      = px_q;
    py_d      = py_q;
    last_d    = last_q;
    icon_lo_d = icon_lo_q;
    icons_d   = icons_q;
    done_d    = 1'b0;

    if (x_q == X_LAST) begin
      x_next_s = '0;
      y_next_s = y_q + Y_W'(1);
    end else begin
      x_next_s = x_q + X_W'(1);
      y_next_s = y_q;
    end

    // busy stays up through the frame_done cycle, which also masks start there.
    if (done_q) begin
      busy_d = 1'b0;
    end else begin
      busy_d = busy_q;
    end

    case (state_q)
      IDLE: begin
        if (start && !busy_q) begin
          state_d = READ;
          x_d     = '0;
          y_d     = '0;
          busy_d  = 1'b1;
          addr_d  = pixel_address('0, '0);
        end else begin
          state_d = IDLE;
        end
      end
      READ: begin
        state_d = CAPTURE;
      end
      CAPTURE: begin
        pix_d   = vram_q[y_q[1:0]];
        px_d    = x_q;
        py_d    = y_q;
        last_d  = (x_q == X_LAST) && (y_q == Y_LAST);
        valid_d = 1'b1;
        state_d = OFFER;
      end
      OFFER: begin
        if (pixel_ready) begin
          valid_d = 1'b0;
          x_d     = x_next_s;
          y_d     = y_next_s;
          if (last_q) begin
            state_d = ICON0;
            addr_d  = LCD_ICON_BASE;
          end else begin
            state_d = READ;
            addr_d  = pixel_address(x_next_s, y_next_s);
          end
        end else begin
          state_d = OFFER;
        end
      end
      ICON0: begin
        addr_d  = LCD_ICON_BASE + 8'd1;
        state_d = ICON1;
      end
      ICON1: begin
        icon_lo_d = vram_q;
        state_d   = ICON2;
      end
      ICON2: begin
        icons_d = {vram_q, icon_lo_q};
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign busy         = busy_q;
  assign vram_address = addr_q;
  assign pixel_valid  = valid_q;
  assign pixel        = pix_q;
  assign pixel_x      = px_q;
  assign pixel_y      = py_q;
  assign pixel_last   = last_q;
  assign icons        = icons_q;
  assign frame_done   = done_q;

endmodule

// File: tb/tb_lcd_frame_scanner.sv
// Directed bench for lcd_frame_scanner with a registered-read video RAM model.
module tb_lcd_frame_scanner;

  logic       clock = 1'b0;
  logic       reset;
  logic       start;
  logic       busy;
  logic [7:0] vram_address;
  logic [3:0] vram_q;
  logic       pixel_valid;
  logic       pixel_ready;
  logic       pixel;
  logic [4:0] pixel_x;
  logic [3:0] pixel_y;
  logic       pixel_last;
  logic [7:0] icons;
  logic       frame_done;

  logic [3:0] mem [256];
  int n_cmp = 0;
  int n_err = 0;

  always #5 clock = ~clock;

  // Port B of the video RAM: registered read, one cycle latency.
  always @(posedge clock) vram_q <= mem[vram_address];

  lcd_frame_scanner dut (
    .clock        (clock),
    .reset        (reset),
    .start        (start),
    .busy         (busy),
    .vram_address (vram_address),
    .vram_q       (vram_q),
    .pixel_valid  (pixel_valid),
    .pixel_ready  (pixel_ready),
    .pixel        (pixel),
    .pixel_x      (pixel_x),
    .pixel_y      (pixel_y),
    .pixel_last   (pixel_last),
    .icons        (icons),
    .frame_done   (frame_done)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic ref_px(input int x, input int y);
    logic [3:0] n;
    n = mem[(y / 4) * 32 + x];
    return n[y % 4];
  endfunction

  // Issues start (caller is at a negedge) and consumes one whole frame.
  task automatic run_frame(input string name, input bit rand_ready, input bit restart,
                           input logic [7:0] prev_icons, input logic [7:0] exp_icons,
                           input int exp_ones);
    int hs = 0, ones = 0, lasts = 0, dones = 0;
    int stream_err = 0, stab_err = 0, ib_err = 0, gap_err = 0;
    int first_k = -1, last_acc = -1, done_k = -1;
    bit held = 1'b0, fin = 1'b0;
    logic hp; logic [4:0] hx; logic [3:0] hy; logic hl;
    int ex = 0, ey = 0;
    start = 1'b1;
    for (int k = 1; k <= 10000; k++) begin
      @(negedge clock);
      if (k == 1) start = 1'b0;
      if (restart && k == 50) start = 1'b1;
      if (restart && k == 51) start = 1'b0;
      pixel_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      if (held) begin
        if (!pixel_valid || pixel !== hp || pixel_x !== hx || pixel_y !== hy || pixel_last !== hl)
          stab_err++;
      end
      if (pixel_valid && first_k < 0) first_k = k;
      if (pixel_valid && pixel_ready) begin
        if (pixel_x !== 5'(ex) || pixel_y !== 4'(ey) || pixel !== ref_px(ex, ey) ||
            pixel_last !== ((ex == 31) && (ey == 15)))
          stream_err++;
        if (pixel) ones++;
        if (pixel_last) lasts++;
        if (!rand_ready && last_acc > 0 && (k - last_acc) != 3) gap_err++;
        last_acc = k;
        hs++;
        ex = (ex == 31) ? 0 : ex + 1;
        if (ex == 0) ey = (ey + 1) % 16;
      end
      held = pixel_valid && !pixel_ready;
      hp = pixel; hx = pixel_x; hy = pixel_y; hl = pixel_last;
      if (frame_done) begin
        dones++;
        if (done_k < 0) begin
          done_k = k;
          check_eq({name, "_icons_at_done"}, 32'(icons), 32'(exp_icons));
          if (restart) start = 1'b1;
        end
      end else if (done_k < 0 && icons !== prev_icons) begin
        ib_err++;
      end
      if (done_k > 0 && k == done_k + 1) begin
        start = 1'b0;
        check_eq({name, "_busy_after_done"}, 32'(busy), 32'd0);
        if (!restart) begin
          fin = 1'b1;
          break;
        end
      end
      if (done_k > 0 && k == done_k + 6) begin
        check_eq({name, "_no_second_frame"}, 32'({busy, pixel_valid}), 32'd0);
        fin = 1'b1;
        break;
      end
    end
    check_eq({name, "_finished"}, 32'(fin), 32'd1);
    check_eq({name, "_handshakes"}, 32'(hs), 32'd512);
    check_eq({name, "_stream"}, 32'(stream_err), 32'd0);
    check_eq({name, "_last_count"}, 32'(lasts), 32'd1);
    check_eq({name, "_done_count"}, 32'(dones), 32'd1);
    check_eq({name, "_stable"}, 32'(stab_err), 32'd0);
    check_eq({name, "_icons_before"}, 32'(ib_err), 32'd0);
    check_eq({name, "_icons_held"}, 32'(icons), 32'(exp_icons));
    if (exp_ones >= 0) check_eq({name, "_ones"}, 32'(ones), 32'(exp_ones));
    if (!rand_ready) begin
      check_eq({name, "_first_latency"}, 32'(first_k), 32'd3);
      check_eq({name, "_accept_gap"}, 32'(gap_err), 32'd0);
    end
  endtask

  initial begin
    int dn;
    bit hit;
    reset = 1'b1;
    start = 1'b0;
    pixel_ready = 1'b0;
    for (int a = 0; a < 256; a++) mem[a] = 4'h0;
    mem[0] = 4'b1010;
    repeat (3) @(negedge clock);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_addr", 32'(vram_address), 32'd0);
    check_eq("rst_valid", 32'(pixel_valid), 32'd0);
    check_eq("rst_pixel", 32'({pixel, pixel_x, pixel_y, pixel_last}), 32'd0);
    check_eq("rst_icons", 32'(icons), 32'd0);
    check_eq("rst_done", 32'(frame_done), 32'd0);
    reset = 1'b0;
    @(negedge clock);

    // Only nibble 0 = 1010: pixels (0,1) and (0,3) lit, no icons.
    run_frame("f1", 1'b0, 1'b0, 8'h00, 8'h00, 2);

    for (int a = 0; a < 128; a++) mem[a] = 4'(a) ^ 4'(a >> 4) ^ 4'(a >> 2);
    mem[8'h80] = 4'h5;
    mem[8'h81] = 4'hC;
    @(negedge clock);
    run_frame("f2", 1'b1, 1'b1, 8'h00, 8'hC5, -1);
    @(negedge clock);
    run_frame("f3", 1'b0, 1'b0, 8'hC5, 8'hC5, -1);

    // Reset while pixel (10,5) is being offered.
    @(negedge clock);
    start = 1'b1;
    hit = 1'b0;
    for (int k = 0; k < 3000; k++) begin
      @(negedge clock);
      start = 1'b0;
      if (pixel_valid && pixel_x == 5'd10 && pixel_y == 4'd5) begin
        pixel_ready = 1'b0;
        reset = 1'b1;
        hit = 1'b1;
        break;
      end
      pixel_ready = 1'b1;
    end
    check_eq("rst_mid_reached", 32'(hit), 32'd1);
    @(negedge clock);
    reset = 1'b0;
    check_eq("rst_mid_valid", 32'(pixel_valid), 32'd0);
    check_eq("rst_mid_busy", 32'(busy), 32'd0);
    check_eq("rst_mid_icons", 32'(icons), 32'd0);
    dn = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clock);
      if (frame_done) dn++;
    end
    check_eq("rst_mid_no_done", 32'(dn), 32'd0);
    run_frame("f4", 1'b0, 1'b0, 8'h00, 8'hC5, -1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
